// File: rtl/wb_write_controller.sv
// Write-back sequencer for the register file write port. Merges the
// single-cycle ALU path with a queued memory/multi-cycle path, keeps
// WAW ordering by squashing older queued writes, and offers a
// forwarding lookup over all pending writes.
module wb_write_controller #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_wa,
    input  logic [31:0]   alu_wd,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_wa,
    input  logic [31:0]   mem_wd,
    input  logic [4:0]    q_ra,
    output logic          q_hit,
    output logic [31:0]   q_data,
    output logic [4:0]    WA,
    output logic          WE,
    output logic [31:0]   WD,
    output logic [CW-1:0] pend_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Queue storage and pointers (extra MSB distinguishes full from empty)
    logic [4:0]       qwa_q [DEPTH];
    logic [31:0]      qwd_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;

    // Output stage
    logic             we_q, we_d;
    logic [4:0]       wa_q, wa_d;
    logic [31:0]      wd_q, wd_d;

    logic [PW-1:0]    count;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    fwd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             squash;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign rd_idx     = rd_ptr_q[AW-1:0];
    assign wr_idx     = wr_ptr_q[AW-1:0];
    assign full       = (count == PW'(DEPTH));
    assign empty      = (count == '0);
    assign mem_ready  = !full && !rst;
    // Writes to $0 are consumed by the handshake but never occupy a slot
    assign push       = mem_valid && mem_ready && (mem_wa != 5'd0);
    assign squash     = alu_valid && (alu_wa != 5'd0);
    assign pend_count = CW'(count);

    assign WA = wa_q;
    assign WE = we_q;
    assign WD = wd_q;

    // Commit select: ALU wins, otherwise drain the queue head
    always_comb begin
        pop  = 1'b0;
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (alu_valid) begin
            wa_d = alu_wa;
            wd_d = alu_wd;
            we_d = (alu_wa != 5'd0);
        end else if (!empty) begin
            pop  = 1'b1;
            wa_d = qwa_q[rd_idx];
            wd_d = qwd_q[rd_idx];
            we_d = live_q[rd_idx];
        end
    end

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // Pointer and output-stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    // Queue contents; the push is applied after the squash so a same-cycle
    // push of the squashed address stays live (it is younger than the ALU write)
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q <= '0;
        end else begin
            if (squash) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (qwa_q[i] == alu_wa) begin
                        live_q[i] <= 1'b0;
                    end
                end
            end
            if (push) begin
                qwa_q[wr_idx]  <= mem_wa;
                qwd_q[wr_idx]  <= mem_wd;
                live_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Forwarding: output stage is the oldest candidate; queue entries are
    // scanned oldest to youngest so the youngest live match wins
    always_comb begin
        q_hit   = 1'b0;
        q_data  = '0;
        fwd_idx = '0;
        if (q_ra != 5'd0) begin
            if (we_q && (wa_q == q_ra)) begin
                q_hit  = 1'b1;
                q_data = wd_q;
            end
            for (int unsigned k = 0; k < DEPTH; k++) begin
                fwd_idx = rd_idx + AW'(k);
                if ((PW'(k) < count) && live_q[fwd_idx] && (qwa_q[fwd_idx] == q_ra)) begin
                    q_hit  = 1'b1;
                    q_data = qwd_q[fwd_idx];
                end
            end
        end
    end

endmodule
